// File: rtl/xge_pkt_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xge_pkt_tx_arbiter
// Purpose  : Packet-granular round-robin arbiter. It merges NUM_CH packet
//            sources onto the single pkt_tx_* transmit interface of the
//            xge_mac core in the 156.25 MHz domain. A grant is held for a
//            whole packet. Backpressure comes from pkt_tx_full, and a
//            protocol-error pulse is raised when a sop is seen inside a
//            packet.
// Ports    : clk_156m25, reset_156m25_n  - clock, synchronous active-low reset
//            ch_data/ch_mod/ch_sop/ch_eop/ch_val - per-channel packet words
//            ch_rdy                       - per-channel ready
//            pkt_tx_full                  - MAC FIFO full (backpressure)
//            pkt_tx_data/mod/sop/eop/val  - merged, registered output to MAC
//            grant_id, busy, proto_err    - status
// Revision : 1.0 - initial release
// ============================================================================
module xge_pkt_tx_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int MOD_W  = $clog2(DATA_W / 8)
) (
    input  logic                        clk_156m25,
    input  logic                        reset_156m25_n,
    input  logic [NUM_CH*DATA_W-1:0]    ch_data,
    input  logic [NUM_CH*MOD_W-1:0]     ch_mod,
    input  logic [NUM_CH-1:0]           ch_sop,
    input  logic [NUM_CH-1:0]           ch_eop,
    input  logic [NUM_CH-1:0]           ch_val,
    output logic [NUM_CH-1:0]           ch_rdy,
    input  logic                        pkt_tx_full,
    output logic [DATA_W-1:0]           pkt_tx_data,
    output logic [MOD_W-1:0]            pkt_tx_mod,
    output logic                        pkt_tx_sop,
    output logic                        pkt_tx_eop,
    output logic                        pkt_tx_val,
    output logic [$clog2(NUM_CH)-1:0]   grant_id,
    output logic                        busy,
    output logic                        proto_err
);

    localparam int ID_W = $clog2(NUM_CH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]         state_q,      state_d;
    logic [ID_W-1:0]    grant_q,      grant_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic               first_q,      first_d;

    logic [DATA_W-1:0]  tx_data_q;
    logic [MOD_W-1:0]   tx_mod_q;
    logic               tx_sop_q;
    logic               tx_eop_q;
    logic               tx_val_q;
    logic               err_q;

    // ------------------------------------------------------------------
    // Granted-channel selection
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0]  w_req;
    logic [ID_W-1:0]    w_pick;
    logic               w_req_any;
    logic [DATA_W-1:0]  w_sel_data;
    logic [MOD_W-1:0]   w_sel_mod;
    logic               w_sel_sop;
    logic               w_sel_eop;
    logic               w_sel_val;
    logic               w_xfer;

    // Only a word that carries sop counts as a request. A mid-packet word
    // left over on an idle channel is never granted.
    assign w_req = ch_val & ch_sop;

    // Rotating priority starting at last_grant+1. The loop walks the
    // offsets from farthest to nearest, so the nearest requester after the
    // previous winner is assigned last and wins.
    always_comb begin
        w_pick    = last_grant_q;
        w_req_any = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (w_req[(int'(last_grant_q) + k) % NUM_CH]) begin
                w_pick    = ID_W'((int'(last_grant_q) + k) % NUM_CH);
                w_req_any = 1'b1;
            end
        end
    end

    assign w_sel_data = ch_data[int'(grant_q)*DATA_W +: DATA_W];
    assign w_sel_mod  = ch_mod[int'(grant_q)*MOD_W +: MOD_W];
    assign w_sel_sop  = ch_sop[grant_q];
    assign w_sel_eop  = ch_eop[grant_q];
    assign w_sel_val  = ch_val[grant_q];

    // A word moves only in BUSY, only from the granted channel, and only
    // while the MAC FIFO has room.
    assign w_xfer = (state_q == ST_BUSY) && w_sel_val && !pkt_tx_full;

    always_comb begin
        ch_rdy = '0;
        if (state_q == ST_BUSY) begin
            ch_rdy[grant_q] = !pkt_tx_full;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_d      = first_q;
        if (state_q == ST_IDLE) begin
            // Arbitration is not gated by pkt_tx_full. Only transfers are.
            if (w_req_any) begin
                state_d = ST_BUSY;
                grant_d = w_pick;
                first_d = 1'b1;
            end
        end else begin
            if (w_xfer) begin
                first_d = 1'b0;
                if (w_sel_eop) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_156m25) begin
        if (!reset_156m25_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            // Channel 0 wins the first arbitration after reset.
            last_grant_q <= ID_W'(NUM_CH - 1);
            first_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_mod_q     <= '0;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            tx_val_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            tx_val_q     <= w_xfer;
            tx_sop_q     <= w_xfer & w_sel_sop;
            tx_eop_q     <= w_xfer & w_sel_eop;
            // The modulus is only meaningful on eop, so it is zeroed elsewhere.
            tx_mod_q     <= (w_xfer && w_sel_eop) ? w_sel_mod : '0;
            // Data keeps its last value across idle cycles.
            if (w_xfer) begin
                tx_data_q <= w_sel_data;
            end
            // A sop on any word but the first is flagged. The word is still
            // forwarded and the packet continues.
            err_q        <= w_xfer & w_sel_sop & ~first_q;
        end
    end

    assign pkt_tx_data = tx_data_q;
    assign pkt_tx_mod  = tx_mod_q;
    assign pkt_tx_sop  = tx_sop_q;
    assign pkt_tx_eop  = tx_eop_q;
    assign pkt_tx_val  = tx_val_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q == ST_BUSY);
    assign proto_err   = err_q;

endmodule
`default_nettype wire
